// File: rtl/serial_add_sequencer_if.sv
// Request/result handshake bundle for the bit-serial add/subtract engine.
// The requester uses the master modport and the engine uses the slave modport.
interface serial_add_sequencer_if #(
    parameter int WIDTH = 64
);
    logic             start_valid;
    logic             start_ready;
    logic             sub;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic             busy;

    modport master (
        output start_valid, sub, a_in, b_in, res_ready,
        input  start_ready, res_valid, result, carry_out, overflow, zero, negative, busy
    );

    modport slave (
        input  start_valid, sub, a_in, b_in, res_ready,
        output start_ready, res_valid, result, carry_out, overflow, zero, negative, busy
    );
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract: one full-adder cell evaluated over WIDTH cycles,
// result and ALU flags presented through a valid/ready handshake.
module serial_add_sequencer #(
    parameter int WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    serial_add_sequencer_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             c_q, v_q, z_q, n_q;

    logic             sum_bit, cout, last;
    logic [WIDTH-1:0] final_sum;

    assign sum_bit   = a_q[0] ^ b_q[0] ^ carry;
    assign cout      = (a_q[0] & b_q[0]) | (carry & (a_q[0] ^ b_q[0]));
    assign last      = (cnt == CW'(WIDTH - 1));
    // Sum bits shift into A's MSB, so on the last evaluation A already holds
    // the low WIDTH-1 result bits and only the current sum bit is missing.
    assign final_sum = {sum_bit, a_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start_valid) state_nxt = RUN;
            RUN:     if (last)            state_nxt = DONE;
            DONE:    if (bus.res_ready)   state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
        end else begin
            if (state == IDLE && bus.start_valid) begin
                a_q   <= bus.a_in;
                b_q   <= bus.sub ? ~bus.b_in : bus.b_in;
                carry <= bus.sub;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_q   <= final_sum;
                b_q   <= {1'b0, b_q[WIDTH-1:1]};
                carry <= cout;
                cnt   <= cnt + CW'(1);
                if (last) begin
                    // carry is the carry consumed by the MSB on this evaluation
                    res_q <= final_sum;
                    c_q   <= cout;
                    v_q   <= carry ^ cout;
                    z_q   <= (final_sum == '0);
                    n_q   <= sum_bit;
                end
            end
        end
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.busy        = (state == RUN);
    assign bus.res_valid   = (state == DONE);
    assign bus.result      = res_q;
    assign bus.carry_out   = c_q;
    assign bus.overflow    = v_q;
    assign bus.zero        = z_q;
    assign bus.negative    = n_q;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed and random checks of serial_add_sequencer at WIDTH=8 and WIDTH=64
// against an arithmetic reference model.
module tb_serial_add_sequencer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        sel;           // 0 = WIDTH 8 instance, 1 = WIDTH 64 instance
    logic        sv, sb, rr;
    logic [63:0] a, b;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    serial_add_sequencer_if #(.WIDTH(8))  i8 ();
    serial_add_sequencer_if #(.WIDTH(64)) i64 ();

    assign i8.start_valid  = sv & ~sel;
    assign i8.sub          = sb;
    assign i8.a_in         = a[7:0];
    assign i8.b_in         = b[7:0];
    assign i8.res_ready    = rr & ~sel;
    assign i64.start_valid = sv & sel;
    assign i64.sub         = sb;
    assign i64.a_in        = a;
    assign i64.b_in        = b;
    assign i64.res_ready   = rr & sel;

    serial_add_sequencer #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(i8));
    serial_add_sequencer #(.WIDTH(64)) dut64 (.clk(clk), .reset_n(reset_n), .bus(i64));

    wire [63:0] o_res  = sel ? i64.result : {56'd0, i8.result};
    wire        o_sr   = sel ? i64.start_ready : i8.start_ready;
    wire        o_rv   = sel ? i64.res_valid   : i8.res_valid;
    wire        o_busy = sel ? i64.busy        : i8.busy;
    wire        o_c    = sel ? i64.carry_out   : i8.carry_out;
    wire        o_v    = sel ? i64.overflow    : i8.overflow;
    wire        o_z    = sel ? i64.zero        : i8.zero;
    wire        o_n    = sel ? i64.negative    : i8.negative;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference: w-bit two's-complement add of a and (sub ? ~b : b) plus sub.
    task automatic model(input int w, input logic [63:0] av, input logic [63:0] bv, input logic s,
                         output logic [63:0] r, output logic c, output logic v);
        logic [64:0] mask, am, bm, full;
        mask = (65'd1 << w) - 65'd1;
        am   = {1'b0, av} & mask;
        bm   = (s ? {1'b0, ~bv} : {1'b0, bv}) & mask;
        full = am + bm + {64'd0, s};
        r    = full[63:0] & mask[63:0];
        c    = full[w];
        v    = (am[w-1] == bm[w-1]) && (r[w-1] != am[w-1]);
    endtask

    // One full transaction with latency/busy/flag checks; hold = DONE cycles
    // with res_ready low, optionally toggling request inputs meanwhile.
    task automatic run_op(input logic w64, input logic [63:0] av, input logic [63:0] bv,
                          input logic s, input int hold, input bit toggle);
        int          w, n, lat, bc;
        logic [63:0] er;
        logic        ec, ev;
        sel = w64;
        w   = w64 ? 64 : 8;
        model(w, av, bv, s, er, ec, ev);
        n = 0;
        while (!o_sr && n < 200) begin @(negedge clk); n++; end
        chk("start_ready_idle", {63'd0, o_sr}, 64'd1);
        sv = 1'b1; a = av; b = bv; sb = s;
        @(posedge clk);
        @(negedge clk);
        sv = 1'b0; a = ~av; b = {$urandom, $urandom}; sb = ~s;
        lat = 0; bc = 0;
        while (!o_rv && lat < w + 8) begin
            bc += int'(o_busy);
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(w));
        chk("busy_cycles", 64'(bc), 64'(w));
        chk("result", o_res, er);
        chk("carry_out", {63'd0, o_c}, {63'd0, ec});
        chk("overflow", {63'd0, o_v}, {63'd0, ev});
        chk("zero", {63'd0, o_z}, {63'd0, er == 64'd0});
        chk("negative", {63'd0, o_n}, {63'd0, er[w-1]});
        for (int i = 0; i < hold; i++) begin
            if (toggle) begin sv = ~sv; a = {$urandom, $urandom}; end
            @(negedge clk);
        end
        if (hold > 0) begin
            chk("hold_result", o_res, er);
            chk("hold_carry", {63'd0, o_c}, {63'd0, ec});
            chk("hold_ready_low", {63'd0, o_sr}, 64'd0);
            chk("hold_valid", {63'd0, o_rv}, 64'd1);
        end
        sv = 1'b0; rr = 1'b1;
        @(negedge clk);
        rr = 1'b0;
        chk("idle_valid_low", {63'd0, o_rv}, 64'd0);
        chk("idle_ready", {63'd0, o_sr}, 64'd1);
        chk("idle_hold_result", o_res, er);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; sel = 1'b0; sv = 1'b0; sb = 1'b0; rr = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {63'd0, o_sr}, 64'd1);
        chk("rst_busy", {63'd0, o_busy}, 64'd0);
        chk("rst_valid", {63'd0, o_rv}, 64'd0);
        chk("rst_result", o_res, 64'd0);
        chk("rst_flags", {60'd0, o_c, o_v, o_z, o_n}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, 64'h7F, 64'h01, 1'b0, 0, 1'b0);
        chk("add7f_res", o_res, 64'h80);
        chk("add7f_flags", {60'd0, o_c, o_v, o_z, o_n}, {60'd0, 4'b0101});
        run_op(1'b0, 64'h05, 64'h05, 1'b1, 0, 1'b0);
        chk("sub55_flags", {60'd0, o_c, o_v, o_z, o_n}, {60'd0, 4'b1010});
        run_op(1'b0, 64'h03, 64'h05, 1'b1, 10, 1'b1);
        chk("sub35_res", o_res, 64'hFE);
        chk("sub35_flags", {60'd0, o_c, o_v, o_z, o_n}, {60'd0, 4'b0001});
        run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, 1'b0);
        chk("wrap64_res", o_res, 64'd0);
        chk("wrap64_flags", {60'd0, o_c, o_v, o_z, o_n}, {60'd0, 4'b1010});

        // Abort a WIDTH=8 operation mid-RUN with an asynchronous reset.
        sel = 1'b0;
        sv = 1'b1; a = 64'd5; b = 64'd3; sb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        sv = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", {63'd0, o_busy}, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, o_busy}, 64'd0);
        chk("arst_valid", {63'd0, o_rv}, 64'd0);
        chk("arst_ready", {63'd0, o_sr}, 64'd1);
        chk("arst_result", o_res, 64'd0);
        chk("arst_flags", {60'd0, o_c, o_v, o_z, o_n}, 64'd0);
        @(negedge clk);
        chk("arst_hold_valid", {63'd0, o_rv}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, 64'd1, 64'd1, 1'b0, 0, 1'b0);
        chk("post_rst_res", o_res, 64'd2);

        for (int i = 0; i < 600; i++)
            run_op(1'(i % 2), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom % 2),
                   int'($urandom_range(0, 3)), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
